// File: rtl/cnet_selectmap_emu.sv
// SelectMAP configuration port emulator: PROG_B/INIT_B/DONE handshake, word intake
// with optional BUSY throttling, CRC fault injection and checksum readback in DONE.
module cnet_selectmap_emu #(
  parameter int DATA_WIDTH      = 8,
  parameter int PROG_B_CYCLES   = 10,
  parameter int INIT_B_CYCLES   = 10,
  parameter int BITSTREAM_WORDS = 16,
  parameter int BUSY_PERIOD     = 0
) (
  input  logic                  rp_cclk,
  input  logic                  reset,
  input  logic                  rp_prog_b,
  input  logic                  rp_cs_b,
  input  logic                  rp_rdwr_b,
  input  logic [DATA_WIDTH-1:0] rp_data,
  input  logic                  want_crc_error,
  output logic                  rp_init_b,
  output logic                  rp_done,
  output logic                  rp_busy,
  output logic [DATA_WIDTH-1:0] rp_data_out,
  output logic                  rp_data_oe,
  output logic [15:0]           word_cnt,
  output logic                  err_early_prog,
  output logic                  err_rdwr_chg,
  output logic                  err_overrun
);

  // state   | meaning
  // EMPTY   | unconfigured after reset, init_b low while i counts down
  // IDLE    | recovery from an illegal encoding only, returns to EMPTY
  // PROG_B  | prog_b asserted, i counts the minimum low time
  // INIT_B  | init_b held low after prog_b release
  // PROG    | accepting bitstream words
  // CRC_ERR | bitstream rejected, waits for a new prog_b pulse
  // DONE    | configured, checksum readable
  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    IDLE    = 3'd1,
    PROG_B  = 3'd2,
    INIT_B  = 3'd3,
    PROG    = 3'd4,
    CRC_ERR = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam int I_MAX = (PROG_B_CYCLES > INIT_B_CYCLES) ? PROG_B_CYCLES : INIT_B_CYCLES;
  localparam int I_W   = $clog2(I_MAX + 1);
  localparam logic [I_W-1:0] I_PROG    = I_W'(PROG_B_CYCLES - 1);
  localparam logic [I_W-1:0] I_INIT    = I_W'(INIT_B_CYCLES - 1);
  localparam logic [15:0]    LAST_WORD = 16'(BITSTREAM_WORDS);
  localparam logic [15:0]    BUSY_LAST = 16'(BUSY_PERIOD - 1);

  state_t         state;
  logic [I_W-1:0] i_cnt;
  logic [I_W-1:0] i_dec;
  logic [15:0]    checksum;
  logic [15:0]    busy_cnt;
  logic [15:0]    word_cnt_inc;
  logic [31:0]    data_ext;
  logic           rdwr_lat;
  logic           accept;

  assign i_dec        = (i_cnt == '0) ? '0 : i_cnt - I_W'(1);
  assign word_cnt_inc = word_cnt + 16'd1;
  assign data_ext     = 32'(rp_data);
  assign accept       = !rp_cs_b && !rp_busy && !rp_rdwr_b && !rdwr_lat;

  assign rp_init_b = !(state inside {EMPTY, PROG_B, INIT_B, CRC_ERR});
  assign rp_done   = (state == DONE);

  always_ff @(posedge rp_cclk) begin
    if (reset) begin
      state          <= EMPTY;
      i_cnt          <= I_PROG;
      word_cnt       <= '0;
      checksum       <= '0;
      busy_cnt       <= '0;
      rdwr_lat       <= 1'b0;
      rp_busy        <= 1'b0;
      rp_data_out    <= '0;
      rp_data_oe     <= 1'b0;
      err_early_prog <= 1'b0;
      err_rdwr_chg   <= 1'b0;
      err_overrun    <= 1'b0;
    end else begin
      rp_busy     <= 1'b0;
      rp_data_oe  <= 1'b0;
      rp_data_out <= '0;
      // A fresh prog_b assertion aborts anything except the power-up countdown.
      if (!rp_prog_b && state != EMPTY && state != PROG_B) begin
        state <= PROG_B;
        i_cnt <= I_PROG;
      end else begin
        case (state)
          EMPTY: begin
            if (i_cnt == '0) begin
              state <= INIT_B;
              i_cnt <= I_INIT;
            end else begin
              i_cnt <= i_dec;
            end
          end
          PROG_B: begin
            if (!rp_prog_b) begin
              i_cnt <= i_dec;
            end else if (i_cnt == '0) begin
              state <= INIT_B;
              i_cnt <= I_INIT;
            end else begin
              err_early_prog <= 1'b1;
            end
          end
          INIT_B: begin
            if (i_cnt == '0) begin
              state    <= PROG;
              word_cnt <= '0;
              checksum <= '0;
              busy_cnt <= '0;
              rdwr_lat <= rp_rdwr_b;
            end else begin
              i_cnt <= i_dec;
            end
          end
          PROG: begin
            if (!rp_cs_b && (rp_rdwr_b != rdwr_lat)) err_rdwr_chg <= 1'b1;
            if (accept) begin
              word_cnt <= word_cnt_inc;
              checksum <= 16'(32'(checksum) + data_ext);
              if (want_crc_error) begin
                state <= CRC_ERR;
              end else if (word_cnt_inc == LAST_WORD) begin
                state <= DONE;
              end else if (BUSY_PERIOD > 0) begin
                // busy only fires while staying in PROG
                if (busy_cnt == BUSY_LAST) begin
                  busy_cnt <= '0;
                  rp_busy  <= 1'b1;
                end else begin
                  busy_cnt <= busy_cnt + 16'd1;
                end
              end
            end
          end
          CRC_ERR: begin
          end
          DONE: begin
            if (!rp_cs_b) begin
              if (rp_rdwr_b) begin
                rp_data_out <= DATA_WIDTH'(checksum);
                rp_data_oe  <= 1'b1;
              end else begin
                err_overrun <= 1'b1;
              end
            end
          end
          IDLE: begin
            state <= EMPTY;
            i_cnt <= I_PROG;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnet_selectmap_emu.sv
// Directed bench for cnet_selectmap_emu: default instance (a_*) and a 32-bit
// instance with BUSY_PERIOD=4 (b_*), sharing clock and reset.
module tb_cnet_selectmap_emu;

  logic rp_cclk = 1'b0;
  always #5 rp_cclk = ~rp_cclk;

  logic        reset;

  logic        a_prog_b, a_cs_b, a_rdwr_b, a_crc;
  logic [7:0]  a_data;
  logic        a_init_b, a_done, a_busy, a_oe;
  logic [7:0]  a_dout;
  logic [15:0] a_wcnt;
  logic        a_e_prog, a_e_rdwr, a_e_ovr;

  logic        b_prog_b, b_cs_b, b_rdwr_b, b_crc;
  logic [31:0] b_data;
  logic        b_init_b, b_done, b_busy, b_oe;
  logic [31:0] b_dout;
  logic [15:0] b_wcnt;
  logic        b_e_prog, b_e_rdwr, b_e_ovr;

  int n_chk = 0;
  int n_err = 0;

  cnet_selectmap_emu u_dut_a (
    .rp_cclk(rp_cclk), .reset(reset),
    .rp_prog_b(a_prog_b), .rp_cs_b(a_cs_b), .rp_rdwr_b(a_rdwr_b),
    .rp_data(a_data), .want_crc_error(a_crc),
    .rp_init_b(a_init_b), .rp_done(a_done), .rp_busy(a_busy),
    .rp_data_out(a_dout), .rp_data_oe(a_oe), .word_cnt(a_wcnt),
    .err_early_prog(a_e_prog), .err_rdwr_chg(a_e_rdwr), .err_overrun(a_e_ovr)
  );

  cnet_selectmap_emu #(.DATA_WIDTH(32), .BUSY_PERIOD(4)) u_dut_b (
    .rp_cclk(rp_cclk), .reset(reset),
    .rp_prog_b(b_prog_b), .rp_cs_b(b_cs_b), .rp_rdwr_b(b_rdwr_b),
    .rp_data(b_data), .want_crc_error(b_crc),
    .rp_init_b(b_init_b), .rp_done(b_done), .rp_busy(b_busy),
    .rp_data_out(b_dout), .rp_data_oe(b_oe), .word_cnt(b_wcnt),
    .err_early_prog(b_e_prog), .err_rdwr_chg(b_e_rdwr), .err_overrun(b_e_ovr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rp_cclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic busy_seen;
    logic [18:0] busy_mask;

    reset = 1'b1;
    a_prog_b = 1'b1; a_cs_b = 1'b1; a_rdwr_b = 1'b0; a_crc = 1'b0; a_data = '0;
    b_prog_b = 1'b1; b_cs_b = 1'b1; b_rdwr_b = 1'b0; b_crc = 1'b0; b_data = '0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_init_b", 32'(a_init_b), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_oe", 32'(a_oe), 0);
    check("rst_dout", 32'(a_dout), 0);
    check("rst_wcnt", 32'(a_wcnt), 0);
    check("rst_errs", {29'd0, a_e_prog, a_e_rdwr, a_e_ovr}, 0);

    n = 0;
    while (a_init_b !== 1'b1 && n < 100) begin n++; tick(); end
    check("a_init_low_after_reset", n, 20);

    // 16 writes of 0x01
    a_cs_b = 1'b0; a_rdwr_b = 1'b0; a_data = 8'h01;
    busy_seen = 1'b0;
    for (int k = 0; k < 15; k++) begin tick(); busy_seen |= a_busy; end
    check("a_wcnt15", 32'(a_wcnt), 15);
    check("a_done_early", 32'(a_done), 0);
    tick(); busy_seen |= a_busy;
    check("a_done", 32'(a_done), 1);
    check("a_wcnt16", 32'(a_wcnt), 16);
    check("a_no_busy", 32'(busy_seen), 0);
    check("a_init_b_done", 32'(a_init_b), 1);

    a_rdwr_b = 1'b1;
    tick();
    check("a_rd_oe", 32'(a_oe), 1);
    check("a_rd_data", 32'(a_dout), 32'h10);
    a_cs_b = 1'b1;
    tick();
    check("a_rd_oe_off", 32'(a_oe), 0);
    check("a_rd_data_off", 32'(a_dout), 0);

    // write in DONE
    a_cs_b = 1'b0; a_rdwr_b = 1'b0; a_data = 8'h55;
    tick();
    a_cs_b = 1'b1;
    check("a_overrun", 32'(a_e_ovr), 1);
    check("a_overrun_wcnt", 32'(a_wcnt), 16);
    check("a_rdwr_in_done", 32'(a_e_rdwr), 0);

    // short prog_b pulse
    a_prog_b = 1'b0;
    tick();
    check("a_prog_init_b", 32'(a_init_b), 0);
    check("a_prog_done", 32'(a_done), 0);
    tick(); tick(); tick();
    a_prog_b = 1'b1;
    tick();
    check("a_early_prog", 32'(a_e_prog), 1);
    tick(); tick(); tick();
    check("a_early_stuck", 32'(a_init_b), 0);
    a_prog_b = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    a_prog_b = 1'b1;
    n = 0;
    while (a_init_b !== 1'b1 && n < 100) begin n++; tick(); end
    check("a_init_low_after_prog", n, 11);
    check("a_wcnt_cleared", 32'(a_wcnt), 0);

    // two writes, direction change, then CRC error on word 3
    a_cs_b = 1'b0; a_rdwr_b = 1'b0; a_data = 8'h01;
    tick(); tick();
    check("a_wcnt2", 32'(a_wcnt), 2);
    a_rdwr_b = 1'b1;
    tick();
    check("a_rdwr_chg", 32'(a_e_rdwr), 1);
    check("a_rdwr_not_counted", 32'(a_wcnt), 2);
    a_rdwr_b = 1'b0; a_crc = 1'b1;
    tick();
    a_crc = 1'b0;
    check("a_crc_wcnt", 32'(a_wcnt), 3);
    check("a_crc_init_b", 32'(a_init_b), 0);
    check("a_crc_done", 32'(a_done), 0);
    tick(); tick();
    check("a_crc_hold_wcnt", 32'(a_wcnt), 3);
    check("a_crc_hold_init_b", 32'(a_init_b), 0);
    a_cs_b = 1'b1;

    // re-program with 0xF0..0xFF, checksum 0x0F78 truncated to 8 bits
    a_prog_b = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    a_prog_b = 1'b1;
    n = 0;
    while (a_init_b !== 1'b1 && n < 100) begin n++; tick(); end
    check("a_init_low_reprog", n, 11);
    a_cs_b = 1'b0;
    for (int k = 0; k < 16; k++) begin
      a_data = 8'(8'hF0 + k);
      tick();
    end
    check("a_reprog_done", 32'(a_done), 1);
    check("a_reprog_wcnt", 32'(a_wcnt), 16);
    a_rdwr_b = 1'b1;
    tick();
    a_cs_b = 1'b1;
    check("a_reprog_rd", 32'(a_dout), 32'h78);
    check("a_reprog_oe", 32'(a_oe), 1);
    check("a_sticky_prog", 32'(a_e_prog), 1);
    check("a_sticky_rdwr", 32'(a_e_rdwr), 1);
    check("a_sticky_ovr", 32'(a_e_ovr), 1);

    // reset clears everything
    a_rdwr_b = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("a_rst2_errs", {29'd0, a_e_prog, a_e_rdwr, a_e_ovr}, 0);
    check("a_rst2_init_b", 32'(a_init_b), 0);
    check("a_rst2_done", 32'(a_done), 0);
    check("a_rst2_wcnt", 32'(a_wcnt), 0);
    check("a_rst2_oe", 32'(a_oe), 0);

    // 32-bit instance with busy every 4 words
    n = 0;
    while (b_init_b !== 1'b1 && n < 100) begin n++; tick(); end
    check("b_init_low", n, 20);
    b_cs_b = 1'b0; b_rdwr_b = 1'b0; b_data = 32'h1234_0002;
    busy_mask = '0;
    for (int k = 0; k < 19; k++) begin
      tick();
      busy_mask[k] = b_busy;
      if (k == 17) begin
        check("b_wcnt_18cyc", 32'(b_wcnt), 15);
        check("b_done_18cyc", 32'(b_done), 0);
      end
    end
    check("b_busy_pattern", 32'(busy_mask), 32'h2108);
    check("b_wcnt", 32'(b_wcnt), 16);
    check("b_done", 32'(b_done), 1);
    b_rdwr_b = 1'b1;
    tick();
    b_cs_b = 1'b1;
    check("b_rd_data", b_dout, 32'h20);
    check("b_rd_oe", 32'(b_oe), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
